// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit that owns the HI/LO register pair.
// Multiply is shift-add over a 2*WIDTH accumulator. Divide is restoring
// shift-subtract. Both retire UNROLL bits per ITER cycle.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU (ops 6/7), which add
// the product into {hi,lo}. Without it, ops 6/7 are ignored.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO are written here directly
// PREP  | operand magnitudes, result signs, iteration counter load
// ITER  | UNROLL shift-add / shift-subtract steps per cycle, counter down to 0
// FIX   | two's-complement fixup, HI/LO write, done pulse
module mdu_hilo #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int ITERS = WIDTH / UNROLL;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH:0]   acc_nx;
  logic               neg_q;
  logic               neg_r;
  logic               accept;
  logic               signed_op;
  logic               is_div;
  logic               div_zero;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     part;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // Signed ops are the even codes (MULT, DIV, MADD); divides are codes 2/3.
  assign signed_op = ~op_q[0];
  assign is_div    = op_q[1] & ~op_q[2];
  assign div_zero  = (b_q == '0);
  assign mag_a     = (signed_op && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b     = (signed_op && b_q[WIDTH-1]) ? -b_q : b_q;

  // Sign fixup of the unsigned iteration result; product and quotient share neg_q.
  assign prod = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
  assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] hilo_acc;
  assign hilo_acc = {hi, lo} + prod;
`endif

  // Decide whether a start in IDLE launches an iterative op.
  always_comb begin
    accept = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: accept = start;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU:                  accept = start;
`endif
      default:                            accept = 1'b0;
    endcase
  end

  // One ITER cycle worth of datapath: UNROLL shift-add or restoring steps.
  // acc low half holds the multiplier/dividend, upper WIDTH+1 bits the
  // partial product/remainder; quotient bits shift into the bottom.
  always_comb begin
    acc_nx = acc;
    trial  = '0;
    part   = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_div) begin
        acc_nx = acc_nx << 1;
        trial  = acc_nx[2*WIDTH:WIDTH] - {1'b0, opnd};
        if (!trial[WIDTH]) begin
          acc_nx[2*WIDTH:WIDTH] = trial;
          acc_nx[0]             = 1'b1;
        end
      end else begin
        part   = {1'b0, acc_nx[2*WIDTH-1:WIDTH]} +
                 (acc_nx[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        acc_nx = {part, acc_nx[WIDTH-1:0]} >> 1;
      end
    end
  end

  // Control FSM plus the HI/LO architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      opnd  <= '0;
      acc   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush && state != S_IDLE) begin
        // Abort: HI/LO untouched, no done.
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              state <= S_PREP;
              busy  <= 1'b1;
              op_q  <= op;
              a_q   <= a;
              b_q   <= b;
            end else if (start && op == OP_MTHI) begin
              hi <= a;
            end else if (start && op == OP_MTLO) begin
              lo <= a;
            end
          end
          S_PREP: begin
            acc   <= {{(WIDTH+1){1'b0}}, mag_a};
            opnd  <= mag_b;
            neg_q <= signed_op & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            neg_r <= signed_op & a_q[WIDTH-1];
            cnt   <= CW'(ITERS - 1);
            state <= S_ITER;
          end
          S_ITER: begin
            acc <= acc_nx;
            if (cnt == '0) begin
              state <= S_FIX;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_FIX: begin
            if (is_div) begin
              if (div_zero) begin
                hi <= a_q;
                lo <= '1;
              end else begin
                hi <= rem;
                lo <= quo;
              end
            end
`ifdef MDU_MADD_EN
            else if (op_q[2]) begin
              {hi, lo} <= hilo_acc;
            end
`endif
            else begin
              {hi, lo} <= prod;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed vector table plus hand-written multi-cycle sequences
// for mdu_hilo at WIDTH=32, UNROLL=1.
module tb_mdu_hilo;

  localparam int W   = 32;
  localparam int U   = 1;
  localparam int LAT = W / U + 2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          flush;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs [11];

  mdu_hilo #(.WIDTH(W), .UNROLL(U)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Launch an iterative op, check latency, busy and the resulting HI/LO.
  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int lat;
    bit got;
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    chk({name, "_busy"}, 64'(busy), 64'd1);
    lat = 0;
    got = 1'b0;
    while (lat < 100 && !got) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) got = 1'b1;
    end
    chk({name, "_lat"}, 64'(got ? lat : 0), 64'(LAT));
    chk({name, "_busy_done"}, 64'(busy), 64'd0);
    chk({name, "_hi"}, 64'(hi), 64'(ehi));
    chk({name, "_lo"}, 64'(lo), 64'(elo));
  endtask

  task automatic mov(input logic [2:0] o, input logic [W-1:0] v);
    @(negedge clk);
    start = 1'b1; op = o; a = v; b = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic watch_idle(input int cycles, output bit saw_done, output bit saw_busy);
    saw_done = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
  endtask

  initial begin
    bit sd, sb;
    int n;
    bit got;
    logic [W-1:0] hi_prev, lo_prev;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[6]  = '{OP_MULT,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2};
    vecs[7]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[10] = '{OP_MULTU, 32'h0000000C, 32'h0000000B, 32'h00000000, 32'h00000084};

    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vectors run back-to-back: each start lands in the previous done cycle.
    for (int i = 0; i < 11; i++)
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // MTHI is immediate and silent; a second start mid-MULTU is dropped.
    mov(OP_MTHI, 32'h12345678);
    chk("mthi_hi", 64'(hi), 64'h12345678);
    chk("mthi_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("mthi_nodone", 64'(done), 64'd0);
    start = 1'b1; op = OP_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      if (n == 5) begin start = 1'b1; op = OP_MTHI; a = 32'hDEADBEEF; end
      if (n == 6) chk("busy_mthi_ignored", 64'(hi), 64'h12345678);
      if (n == 8) begin start = 1'b1; op = OP_MULTU; a = 32'h2; b = 32'h3; end
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk("multu_lat", 64'(got ? n : 0), 64'(LAT));
    chk("multu_hi", 64'(hi), 64'hFFFFFFFE);
    chk("multu_lo", 64'(lo), 64'h00000001);
    watch_idle(LAT + 6, sd, sb);
    chk("no_queued_done", 64'(sd), 64'd0);
    chk("no_queued_hi", 64'(hi), 64'hFFFFFFFE);

    // Flush during ITER: busy drops next cycle, no done, HI/LO kept.
    hi_prev = hi; lo_prev = lo;
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    watch_idle(LAT + 6, sd, sb);
    chk("flush_nodone", 64'(sd), 64'd0);
    chk("flush_hi", 64'(hi), 64'(hi_prev));
    chk("flush_lo", 64'(lo), 64'(lo_prev));

    // start and flush together in IDLE: start wins.
    flush = 1'b1;
    run_op("start_flush", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    // Accumulate ops.
    mov(OP_MTHI, 32'h0);
    mov(OP_MTLO, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    run_op("maddu", OP_MADDU, 32'd1, 32'd1, 32'h00000001, 32'h00000000);
    mov(OP_MTLO, 32'd5);
    mov(OP_MTHI, 32'h0);
    run_op("madd", OP_MADD, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF6);
`else
    @(negedge clk);
    start = 1'b1; op = OP_MADDU; a = 32'd1; b = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("maddu_off_busy0", 64'(busy), 64'd0);
    watch_idle(LAT + 6, sd, sb);
    chk("maddu_off_nodone", 64'(sd), 64'd0);
    chk("maddu_off_nobusy", 64'(sb), 64'd0);
    chk("maddu_off_hi", 64'(hi), 64'h0);
    chk("maddu_off_lo", 64'(lo), 64'hFFFFFFFF);
`endif

    // Asynchronous reset mid-ITER clears everything without a clock edge.
    mov(OP_MTHI, 32'hA5A5A5A5);
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_hi", 64'(hi), 64'h0);
    chk("arst_lo", 64'(lo), 64'h0);
    chk("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_idle(LAT + 4, sd, sb);
    chk("arst_nodone", 64'(sd), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
